id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage of the LEGv8 core.
- Consumes the register-file operands (read_data1/read_data2) together with decoded immediate and control bits, and presents them to the ALU/execute stage.
- Two-entry skid buffer with valid/ready handshake on both sides.
- Write-back bypass keeps captured and held operands coherent with register-file writes that land after the read.

---
 rtl/legv8_pkg.sv | 23 ++
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/id_ex_entry.sv | 72 +++++++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 core definitions: datapath widths, decoded-control bit layout
// and the source select used when loading the ID/EX main entry.
package legv8_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 16;

    // Bit positions inside the packed decoded-control word
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMRD     = 1;
    localparam int CTRL_MEMWR     = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_ALUOP_MSB = 7;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_IN   = 2'd1,
        SRC_SKID = 2'd2
    } main_src_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/write-back/execute signal bundle around the ID/EX stage.
// master = the surrounding pipeline, slave = the stage itself.
interface id_ex_stage_if
    import legv8_pkg::*;
#(
    parameter int dataWidth    = DATA_W,
    parameter int addressWidth = ADDR_W,
    parameter int ctrlWidth    = CTRL_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic [addressWidth-1:0] in_rn;
    logic [addressWidth-1:0] in_rm;
    logic [addressWidth-1:0] in_rd;
    logic [dataWidth-1:0]    in_read_data1;
    logic [dataWidth-1:0]    in_read_data2;
    logic [dataWidth-1:0]    in_imm;
    logic [ctrlWidth-1:0]    in_ctrl;

    logic                    wb_reg_write;
    logic [addressWidth-1:0] wb_write_register;
    logic [dataWidth-1:0]    wb_write_data;

    logic                    flush;

    logic                    out_valid;
    logic                    out_ready;
    logic [addressWidth-1:0] out_rn;
    logic [addressWidth-1:0] out_rm;
    logic [addressWidth-1:0] out_rd;
    logic [dataWidth-1:0]    out_op1;
    logic [dataWidth-1:0]    out_op2;
    logic [dataWidth-1:0]    out_imm;
    logic [ctrlWidth-1:0]    out_ctrl;

    modport master (
        output in_valid, in_rn, in_rm, in_rd, in_read_data1, in_read_data2, in_imm, in_ctrl,
        output wb_reg_write, wb_write_register, wb_write_data,
        output flush, out_ready,
        input  in_ready, out_valid, out_rn, out_rm, out_rd, out_op1, out_op2, out_imm, out_ctrl
    );

    modport slave (
        input  in_valid, in_rn, in_rm, in_rd, in_read_data1, in_read_data2, in_imm, in_ctrl,
        input  wb_reg_write, wb_write_register, wb_write_data,
        input  flush, out_ready,
        output in_ready, out_valid, out_rn, out_rm, out_rd, out_op1, out_op2, out_imm, out_ctrl
    );

endinterface

// File: rtl/id_ex_entry.sv
// One ID/EX storage entry. Load data passes through the write-back bypass on
// the way in, and held operands keep tracking write-back while valid.
module id_ex_entry
    import legv8_pkg::*;
#(
    parameter int dataWidth    = DATA_W,
    parameter int addressWidth = ADDR_W,
    parameter int ctrlWidth    = CTRL_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    valid_d,
    input  logic [addressWidth-1:0] ld_rn,
    input  logic [addressWidth-1:0] ld_rm,
    input  logic [addressWidth-1:0] ld_rd,
    input  logic [dataWidth-1:0]    ld_op1,
    input  logic [dataWidth-1:0]    ld_op2,
    input  logic [dataWidth-1:0]    ld_imm,
    input  logic [ctrlWidth-1:0]    ld_ctrl,
    input  logic                    wb_reg_write,
    input  logic [addressWidth-1:0] wb_write_register,
    input  logic [dataWidth-1:0]    wb_write_data,
    output logic                    valid,
    output logic [addressWidth-1:0] rn,
    output logic [addressWidth-1:0] rm,
    output logic [addressWidth-1:0] rd,
    output logic [dataWidth-1:0]    op1,
    output logic [dataWidth-1:0]    op2,
    output logic [dataWidth-1:0]    imm,
    output logic [ctrlWidth-1:0]    ctrl
);

    function automatic logic [dataWidth-1:0] fwd(
        input logic                    we,
        input logic [addressWidth-1:0] wreg,
        input logic [dataWidth-1:0]    wdata,
        input logic [addressWidth-1:0] idx,
        input logic [dataWidth-1:0]    cur
    );
        // No zero-register exemption: x31 forwards like any other index
        return (we && (wreg == idx)) ? wdata : cur;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            rn    <= '0;
            rm    <= '0;
            rd    <= '0;
            op1   <= '0;
            op2   <= '0;
            imm   <= '0;
            ctrl  <= '0;
        end else begin
            valid <= valid_d;
            if (load) begin
                rn   <= ld_rn;
                rm   <= ld_rm;
                rd   <= ld_rd;
                op1  <= fwd(wb_reg_write, wb_write_register, wb_write_data, ld_rn, ld_op1);
                op2  <= fwd(wb_reg_write, wb_write_register, wb_write_data, ld_rm, ld_op2);
                imm  <= ld_imm;
                ctrl <= ld_ctrl;
            end else if (valid) begin
                op1 <= fwd(wb_reg_write, wb_write_register, wb_write_data, rn, op1);
                op2 <= fwd(wb_reg_write, wb_write_register, wb_write_data, rm, op2);
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// LEGv8 decode-to-execute stage: two-entry skid buffer (main drives execute,
// skid backs it up) with write-back bypass on capture and while held.
module id_ex_stage
    import legv8_pkg::*;
#(
    parameter int dataWidth    = DATA_W,
    parameter int addressWidth = ADDR_W,
    parameter int ctrlWidth    = CTRL_W
) (
    input  logic         clock,
    input  logic         reset_n,
    id_ex_stage_if.slave bus
);

    logic                    main_valid;
    logic [addressWidth-1:0] main_rn;
    logic [addressWidth-1:0] main_rm;
    logic [addressWidth-1:0] main_rd;
    logic [dataWidth-1:0]    main_op1;
    logic [dataWidth-1:0]    main_op2;
    logic [dataWidth-1:0]    main_imm;
    logic [ctrlWidth-1:0]    main_ctrl;

    logic                    skid_valid;
    logic [addressWidth-1:0] skid_rn;
    logic [addressWidth-1:0] skid_rm;
    logic [addressWidth-1:0] skid_rd;
    logic [dataWidth-1:0]    skid_op1;
    logic [dataWidth-1:0]    skid_op2;
    logic [dataWidth-1:0]    skid_imm;
    logic [ctrlWidth-1:0]    skid_ctrl;

    logic                    accept;
    logic                    drain;
    logic                    main_free;
    main_src_e               main_src;
    logic                    main_load;
    logic                    main_valid_d;
    logic                    skid_load;
    logic                    skid_valid_d;

    logic [addressWidth-1:0] ld_rn;
    logic [addressWidth-1:0] ld_rm;
    logic [addressWidth-1:0] ld_rd;
    logic [dataWidth-1:0]    ld_op1;
    logic [dataWidth-1:0]    ld_op2;
    logic [dataWidth-1:0]    ld_imm;
    logic [ctrlWidth-1:0]    ld_ctrl;

    // in_ready comes straight off the skid valid flop, so it is registered
    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid;
    assign drain        = main_valid && bus.out_ready;
    assign main_free    = !main_valid || drain;

    // Skid only fills while main is held, so a full skid always sits behind a
    // valid main and in_ready is low whenever it moves forward.
    always_comb begin
        main_src     = SRC_HOLD;
        main_valid_d = main_valid;
        skid_load    = 1'b0;
        skid_valid_d = skid_valid;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_src     = SRC_SKID;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_src     = SRC_IN;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    assign main_load = (main_src != SRC_HOLD);

    always_comb begin
        ld_rn   = bus.in_rn;
        ld_rm   = bus.in_rm;
        ld_rd   = bus.in_rd;
        ld_op1  = bus.in_read_data1;
        ld_op2  = bus.in_read_data2;
        ld_imm  = bus.in_imm;
        ld_ctrl = bus.in_ctrl;
        if (main_src == SRC_SKID) begin
            ld_rn   = skid_rn;
            ld_rm   = skid_rm;
            ld_rd   = skid_rd;
            ld_op1  = skid_op1;
            ld_op2  = skid_op2;
            ld_imm  = skid_imm;
            ld_ctrl = skid_ctrl;
        end
    end

    id_ex_entry #(
        .dataWidth(dataWidth), .addressWidth(addressWidth), .ctrlWidth(ctrlWidth)
    ) u_main (
        .clock(clock), .reset_n(reset_n),
        .load(main_load), .valid_d(main_valid_d),
        .ld_rn(ld_rn), .ld_rm(ld_rm), .ld_rd(ld_rd),
        .ld_op1(ld_op1), .ld_op2(ld_op2), .ld_imm(ld_imm), .ld_ctrl(ld_ctrl),
        .wb_reg_write(bus.wb_reg_write), .wb_write_register(bus.wb_write_register),
        .wb_write_data(bus.wb_write_data),
        .valid(main_valid), .rn(main_rn), .rm(main_rm), .rd(main_rd),
        .op1(main_op1), .op2(main_op2), .imm(main_imm), .ctrl(main_ctrl)
    );

    id_ex_entry #(
        .dataWidth(dataWidth), .addressWidth(addressWidth), .ctrlWidth(ctrlWidth)
    ) u_skid (
        .clock(clock), .reset_n(reset_n),
        .load(skid_load), .valid_d(skid_valid_d),
        .ld_rn(bus.in_rn), .ld_rm(bus.in_rm), .ld_rd(bus.in_rd),
        .ld_op1(bus.in_read_data1), .ld_op2(bus.in_read_data2),
        .ld_imm(bus.in_imm), .ld_ctrl(bus.in_ctrl),
        .wb_reg_write(bus.wb_reg_write), .wb_write_register(bus.wb_write_register),
        .wb_write_data(bus.wb_write_data),
        .valid(skid_valid), .rn(skid_rn), .rm(skid_rm), .rd(skid_rd),
        .op1(skid_op1), .op2(skid_op2), .imm(skid_imm), .ctrl(skid_ctrl)
    );

    assign bus.out_valid = main_valid;
    assign bus.out_rn    = main_rn;
    assign bus.out_rm    = main_rm;
    assign bus.out_rd    = main_rd;
    assign bus.out_op1   = main_op1;
    assign bus.out_op2   = main_op2;
    assign bus.out_imm   = main_imm;
    assign bus.out_ctrl  = main_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, ordering, bypass and flush.
module tb_id_ex_stage;
    import legv8_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [15:0] CTRL_ADD = 16'(1 << CTRL_REGWRITE) | 16'(2 << CTRL_ALUOP_LSB);
    localparam logic [15:0] CTRL_LD  = 16'(1 << CTRL_REGWRITE) | 16'(1 << CTRL_MEMRD);
    localparam logic [15:0] CTRL_ST  = 16'(1 << CTRL_MEMWR);
    localparam logic [15:0] CTRL_BR  = 16'(1 << CTRL_BRANCH) | 16'(7 << CTRL_ALUOP_LSB);

    id_ex_stage_if #(.dataWidth(64), .addressWidth(5), .ctrlWidth(16)) bus ();

    id_ex_stage #(.dataWidth(64), .addressWidth(5), .ctrlWidth(16)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] imm, input logic [15:0] ctrl);
        bus.in_valid      = 1'b1;
        bus.in_rn         = rn;
        bus.in_rm         = rm;
        bus.in_rd         = rd;
        bus.in_read_data1 = d1;
        bus.in_read_data2 = d2;
        bus.in_imm        = imm;
        bus.in_ctrl       = ctrl;
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [63:0] d);
        bus.wb_reg_write      = we;
        bus.wb_write_register = r;
        bus.wb_write_data     = d;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_rn = '0; bus.in_rm = '0; bus.in_rd = '0;
        bus.in_read_data1 = '0; bus.in_read_data2 = '0; bus.in_imm = '0; bus.in_ctrl = '0;
        wb(1'b0, 5'd0, 64'd0);
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_active: valid/ready got %b required 01", {bus.out_valid, bus.in_ready});
        end
        reset_n = 1'b1;
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_op1} !== {2'b01, 64'd0}) begin
            errors++;
            $display("FAIL reset_release: valid/ready=%b op1=%h required 01 op1=0",
                     {bus.out_valid, bus.in_ready}, bus.out_op1);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        offer(5'd3, 5'd4, 5'd1, 64'h11, 64'h22, 64'h5, CTRL_ADD);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_op1, bus.out_op2, bus.out_rn, bus.out_rm, bus.out_rd,
             bus.out_imm, bus.out_ctrl}
            !== {1'b1, 64'h11, 64'h22, 5'd3, 5'd4, 5'd1, 64'h5, CTRL_ADD}) begin
            errors++;
            $display("FAIL single_out: valid=%b op1=%h op2=%h rd=%0d ctrl=%h required 1 11 22 1 %h",
                     bus.out_valid, bus.out_op1, bus.out_op2, bus.out_rd, bus.out_ctrl, CTRL_ADD);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: out_valid got %b required 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        offer(5'd1, 5'd2, 5'd10, 64'hA1, 64'hA2, 64'd0, CTRL_ADD);
        step();
        offer(5'd1, 5'd2, 5'd11, 64'hB1, 64'hB2, 64'd0, CTRL_LD);
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_rd} !== {2'b10, 5'd10}) begin
            errors++;
            $display("FAIL bp_full: valid/ready=%b rd=%0d required 10 rd=10",
                     {bus.out_valid, bus.in_ready}, bus.out_rd);
        end
        offer(5'd1, 5'd2, 5'd12, 64'hC1, 64'hC2, 64'd0, CTRL_ST);
        step();
        checks++;
        if ({bus.in_ready, bus.out_rd, bus.out_op1} !== {1'b0, 5'd10, 64'hA1}) begin
            errors++;
            $display("FAIL bp_hold: ready=%b rd=%0d op1=%h required 0 10 a1",
                     bus.in_ready, bus.out_rd, bus.out_op1);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_rd, bus.out_op1} !== {2'b11, 5'd11, 64'hB1}) begin
            errors++;
            $display("FAIL bp_second: valid/ready=%b rd=%0d op1=%h required 11 11 b1",
                     {bus.out_valid, bus.in_ready}, bus.out_rd, bus.out_op1);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_rd, bus.out_op2, bus.out_ctrl} !== {1'b1, 5'd12, 64'hC2, CTRL_ST}) begin
            errors++;
            $display("FAIL bp_third: valid=%b rd=%0d op2=%h required 1 12 c2",
                     bus.out_valid, bus.out_rd, bus.out_op2);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: out_valid got %b required 0 (duplicate)", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(5'd0, 5'd0, 5'(20 + i), 64'(i * 16), 64'd0, 64'(i), CTRL_BR);
            step();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_rd, bus.out_imm} !== {2'b11, 5'(20 + i), 64'(i)}) begin
                errors++;
                $display("FAIL b2b_%0d: valid/ready=%b rd=%0d imm=%h required 11 rd=%0d",
                         i, {bus.out_valid, bus.in_ready}, bus.out_rd, bus.out_imm, 20 + i);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_capture_bypass();
        bus.out_ready = 1'b0;
        offer(5'd5, 5'd6, 5'd2, 64'hAAAA, 64'h6666, 64'd0, CTRL_ADD);
        wb(1'b1, 5'd5, 64'hBEEF);
        step();
        bus.in_valid = 1'b0;
        wb(1'b0, 5'd0, 64'd0);
        checks++;
        if ({bus.out_op1, bus.out_op2} !== {64'hBEEF, 64'h6666}) begin
            errors++;
            $display("FAIL capture_rn: op1=%h op2=%h required beef 6666", bus.out_op1, bus.out_op2);
        end
        bus.out_ready = 1'b1;
        offer(5'd31, 5'd31, 5'd3, 64'h1, 64'h2, 64'd0, CTRL_ADD);
        wb(1'b1, 5'd31, 64'hF00D);
        step();
        bus.in_valid = 1'b0;
        wb(1'b0, 5'd0, 64'd0);
        checks++;
        if ({bus.out_rd, bus.out_op1, bus.out_op2} !== {5'd3, 64'hF00D, 64'hF00D}) begin
            errors++;
            $display("FAIL capture_x31_both: rd=%0d op1=%h op2=%h required 3 f00d f00d",
                     bus.out_rd, bus.out_op1, bus.out_op2);
        end
        step();
    endtask

    task automatic test_hold_bypass();
        bus.out_ready = 1'b0;
        offer(5'd2, 5'd7, 5'd4, 64'h100, 64'h200, 64'd0, CTRL_ADD);
        step();
        offer(5'd8, 5'd9, 5'd5, 64'h80, 64'h90, 64'd0, CTRL_ADD);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_op1, bus.out_op2} !== {64'h100, 64'h200}) begin
            errors++;
            $display("FAIL hold_stable: op1=%h op2=%h required 100 200", bus.out_op1, bus.out_op2);
        end
        wb(1'b1, 5'd7, 64'h1234);
        step();
        checks++;
        if ({bus.out_op1, bus.out_op2} !== {64'h100, 64'h1234}) begin
            errors++;
            $display("FAIL hold_rm: op1=%h op2=%h required 100 1234", bus.out_op1, bus.out_op2);
        end
        wb(1'b1, 5'd2, 64'h5555);
        step();
        checks++;
        if ({bus.out_op1, bus.out_op2} !== {64'h5555, 64'h1234}) begin
            errors++;
            $display("FAIL hold_rn_only: op1=%h op2=%h required 5555 1234", bus.out_op1, bus.out_op2);
        end
        wb(1'b1, 5'd9, 64'h999);
        step();
        bus.out_ready = 1'b1;
        wb(1'b1, 5'd8, 64'h888);
        step();
        wb(1'b0, 5'd0, 64'd0);
        checks++;
        if ({bus.out_valid, bus.out_rd, bus.out_op1, bus.out_op2} !== {1'b1, 5'd5, 64'h888, 64'h999}) begin
            errors++;
            $display("FAIL hold_skid_move: valid=%b rd=%0d op1=%h op2=%h required 1 5 888 999",
                     bus.out_valid, bus.out_rd, bus.out_op1, bus.out_op2);
        end
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        offer(5'd1, 5'd1, 5'd13, 64'h1, 64'h1, 64'd0, CTRL_ADD);
        step();
        offer(5'd1, 5'd1, 5'd14, 64'h2, 64'h2, 64'd0, CTRL_ADD);
        step();
        offer(5'd1, 5'd1, 5'd15, 64'h3, 64'h3, 64'd0, CTRL_ADD);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full: valid/ready=%b required 01", {bus.out_valid, bus.in_ready});
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak_%0d: out_valid=%b rd=%0d required 0", i, bus.out_valid, bus.out_rd);
            end
        end
        bus.out_ready = 1'b0;
        offer(5'd1, 5'd1, 5'd16, 64'h4, 64'h4, 64'd0, CTRL_ADD);
        step();
        offer(5'd1, 5'd1, 5'd17, 64'h5, 64'h5, 64'd0, CTRL_ADD);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        offer(5'd1, 5'd1, 5'd18, 64'h6, 64'h6, 64'd0, CTRL_LD);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_rd, bus.out_op1} !== {2'b11, 5'd18, 64'h6}) begin
            errors++;
            $display("FAIL flush_accept_discard: valid/ready=%b rd=%0d op1=%h required 11 18 6",
                     {bus.out_valid, bus.in_ready}, bus.out_rd, bus.out_op1);
        end
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        offer(5'd1, 5'd1, 5'd19, 64'h77, 64'h77, 64'd0, CTRL_ADD);
        step();
        offer(5'd1, 5'd1, 5'd20, 64'h78, 64'h78, 64'd0, CTRL_ADD);
        step();
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_op1, bus.out_rd} !== {2'b01, 64'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset_mid: valid/ready=%b op1=%h rd=%0d required 01 0 0",
                     {bus.out_valid, bus.in_ready}, bus.out_op1, bus.out_rd);
        end
        step();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_residue: out_valid got %b required 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_capture_bypass();
        test_hold_bypass();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
